// File: rtl/fight_pkg.sv
// Shared fight-scene encodings: state codes, cursor options and skill damage table.
// The renderer imports this package so both sides agree on fight_state values.
package fight_pkg;

   typedef enum logic [2:0] {
      ST_IDLE           = 3'd0,
      ST_MENU           = 3'd1,
      ST_CHOOSING_SKILL = 3'd2,
      ST_ANIM_P1        = 3'd3,
      ST_ANIM_P2        = 3'd4,
      ST_HPRED_P1       = 3'd5,
      ST_HPRED_P2       = 3'd6,
      ST_OVER           = 3'd7
   } fight_state_e;

   localparam logic [3:0] OPT_1 = 4'd1;
   localparam logic [3:0] OPT_2 = 4'd2;
   localparam logic [3:0] OPT_3 = 4'd3;
   localparam logic [3:0] OPT_4 = 4'd4;

   localparam logic [7:0] SKILL_DMG [1:4] = '{8'd20, 8'd30, 8'd10, 8'd40};

   // Out-of-range options deal no damage rather than indexing past the table.
   function automatic logic [7:0] skill_dmg(input logic [3:0] opt);
      logic [7:0] dmg;
      case (opt)
         OPT_1:   dmg = SKILL_DMG[1];
         OPT_2:   dmg = SKILL_DMG[2];
         OPT_3:   dmg = SKILL_DMG[3];
         OPT_4:   dmg = SKILL_DMG[4];
         default: dmg = 8'd0;
      endcase
      return dmg;
   endfunction

endpackage

// File: rtl/fight_hp_drain.sv
// HP drain helper: ticks every DRAIN_CYCLES while active, removes one point of HP and
// pending damage per tick, and flags done on the tick where either has reached zero.
module fight_hp_drain
   import fight_pkg::*;
#(
   parameter int DRAIN_CYCLES = 1000000,
   parameter int CNT_W        = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       active,
   input  logic       clr,
   input  logic [7:0] hp,
   input  logic [7:0] pend,
   output logic [7:0] hp_nx,
   output logic [7:0] pend_nx,
   output logic       done
);

   logic [CNT_W-1:0] cnt;
   logic             tick;
   logic             dec;

   assign tick    = active && (cnt == CNT_W'(DRAIN_CYCLES - 1));
   assign done    = tick && ((pend == 8'd0) || (hp == 8'd0));
   assign dec     = tick && !done;
   assign hp_nx   = dec ? hp - 8'd1 : hp;
   assign pend_nx = dec ? pend - 8'd1 : pend;

   always_ff @(posedge clk) begin
      if (rst || clr || !active || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/fight_ctrl.sv
// Battle-phase controller: turns one-pulse keys into fight_state, cursor and HP for the renderer.
// Define FIGHT_CTRL_LFSR_EN to draw enemy damage from an 8-bit LFSR instead of ENEMY_DMG.
module fight_ctrl
   import fight_pkg::*;
#(
   parameter int HP_MAX       = 200,
   parameter int ANIM_CYCLES  = 25000000,
   parameter int DRAIN_CYCLES = 1000000,
   parameter int ENEMY_DMG    = 25
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fight_start,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_enter,
   input  logic       key_back,
   output logic [5:0] fight_state,
   output logic [3:0] option_state,
   output logic [7:0] p1_cur_hp,
   output logic [7:0] p2_cur_hp,
   output logic       fight_over,
   output logic       winner
);

   localparam int CNT_MAX = (ANIM_CYCLES > DRAIN_CYCLES) ? ANIM_CYCLES : DRAIN_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [7:0] HP_INIT = 8'(HP_MAX);

   fight_state_e     state, state_nx;
   logic [3:0]       opt, opt_nx;
   logic [7:0]       p1_hp, p1_hp_nx;
   logic [7:0]       p2_hp, p2_hp_nx;
   logic [7:0]       pend, pend_nx;
   logic             winner_r, winner_nx;
   logic             over_r;
   logic [CNT_W-1:0] anim_cnt;
   logic             anim_done;
   logic             in_anim;
   logic             drain_active;
   logic             drain_clr;
   logic             drain_done;
   logic [7:0]       tgt_hp;
   logic [7:0]       tgt_hp_nx;
   logic [7:0]       drain_pend_nx;
   logic [7:0]       enemy_dmg;

   // 2x2 grid: one move per cycle, clamped at the edges.
   function automatic logic [3:0] move_cursor(input logic [3:0] o, input logic up,
                                              input logic dn, input logic lf, input logic rt);
      logic [3:0] r;
      r = o;
      if (up) begin
         if (o == OPT_3 || o == OPT_4) r = o - 4'd2;
      end else if (dn) begin
         if (o == OPT_1 || o == OPT_2) r = o + 4'd2;
      end else if (lf) begin
         if (o == OPT_2 || o == OPT_4) r = o - 4'd1;
      end else if (rt) begin
         if (o == OPT_1 || o == OPT_3) r = o + 4'd1;
      end
      return r;
   endfunction

`ifdef FIGHT_CTRL_LFSR_EN
   logic [7:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= 8'hA5;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   assign enemy_dmg = skill_dmg({2'b00, lfsr[1:0]} + 4'd1);
`else
   assign enemy_dmg = 8'(ENEMY_DMG);
`endif

   assign in_anim      = (state == ST_ANIM_P1) || (state == ST_ANIM_P2);
   assign anim_done    = (anim_cnt == CNT_W'(ANIM_CYCLES - 1));
   assign drain_active = (state == ST_HPRED_P1) || (state == ST_HPRED_P2);
   assign tgt_hp       = (state == ST_HPRED_P1) ? p1_hp : p2_hp;
   assign drain_clr    = (state_nx != state) || fight_start;

   fight_hp_drain #(
      .DRAIN_CYCLES (DRAIN_CYCLES),
      .CNT_W        (CNT_W)
   ) u_drain (
      .clk     (clk),
      .rst     (rst),
      .active  (drain_active),
      .clr     (drain_clr),
      .hp      (tgt_hp),
      .pend    (pend),
      .hp_nx   (tgt_hp_nx),
      .pend_nx (drain_pend_nx),
      .done    (drain_done)
   );

   always_comb begin
      state_nx  = state;
      opt_nx    = opt;
      p1_hp_nx  = p1_hp;
      p2_hp_nx  = p2_hp;
      pend_nx   = pend;
      winner_nx = winner_r;
      if (fight_start) begin
         state_nx = ST_MENU;
         opt_nx   = OPT_1;
         p1_hp_nx = HP_INIT;
         p2_hp_nx = HP_INIT;
      end else begin
         case (state)
            ST_MENU: begin
               // Enter and back consume the cycle even when they have no effect here.
               if (key_enter) begin
                  if (opt == OPT_1) begin
                     state_nx = ST_CHOOSING_SKILL;
                     opt_nx   = OPT_1;
                  end
               end else if (!key_back) begin
                  opt_nx = move_cursor(opt, key_up, key_down, key_left, key_right);
               end
            end
            ST_CHOOSING_SKILL: begin
               if (key_enter) begin
                  pend_nx  = skill_dmg(opt);
                  state_nx = ST_ANIM_P1;
               end else if (key_back) begin
                  state_nx = ST_MENU;
                  opt_nx   = OPT_1;
               end else begin
                  opt_nx = move_cursor(opt, key_up, key_down, key_left, key_right);
               end
            end
            ST_ANIM_P1: if (anim_done) state_nx = ST_HPRED_P2;
            ST_ANIM_P2: if (anim_done) state_nx = ST_HPRED_P1;
            ST_HPRED_P2: begin
               p2_hp_nx = tgt_hp_nx;
               pend_nx  = drain_pend_nx;
               if (drain_done) begin
                  if (p2_hp == 8'd0) begin
                     state_nx  = ST_OVER;
                     winner_nx = 1'b0;
                  end else begin
                     state_nx = ST_ANIM_P2;
                     pend_nx  = enemy_dmg;
                  end
               end
            end
            ST_HPRED_P1: begin
               p1_hp_nx = tgt_hp_nx;
               pend_nx  = drain_pend_nx;
               if (drain_done) begin
                  if (p1_hp == 8'd0) begin
                     state_nx  = ST_OVER;
                     winner_nx = 1'b1;
                  end else begin
                     state_nx = ST_MENU;
                     opt_nx   = OPT_1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         opt      <= OPT_1;
         p1_hp    <= HP_INIT;
         p2_hp    <= HP_INIT;
         pend     <= 8'd0;
         winner_r <= 1'b0;
         over_r   <= 1'b0;
         anim_cnt <= '0;
      end else begin
         state    <= state_nx;
         opt      <= opt_nx;
         p1_hp    <= p1_hp_nx;
         p2_hp    <= p2_hp_nx;
         pend     <= pend_nx;
         winner_r <= winner_nx;
         over_r   <= (state_nx == ST_OVER);
         if (drain_clr) begin
            anim_cnt <= '0;
         end else if (in_anim) begin
            anim_cnt <= anim_cnt + 1'b1;
         end
      end
   end

   assign fight_state  = {3'b000, state};
   assign option_state = opt;
   assign p1_cur_hp    = p1_hp;
   assign p2_cur_hp    = p2_hp;
   assign fight_over   = over_r;
   assign winner       = winner_r;

endmodule
